// File: rtl/quant_conv_relu2d_stream.sv
// Streaming quantized 2-D convolution + ReLU, one multiply-accumulate per cycle, with stride,
// on-the-fly zero padding and a valid/ready output. Optional per-channel scale: QCONV_PER_CHANNEL_SCALE_EN.
module quant_conv_relu2d_stream #(
   parameter int          IN_CH  = 1,
   parameter int          OUT_CH = 32,
   parameter int          K      = 3,
   parameter int          IN_W   = 28,
   parameter int          IN_H   = 28,
   parameter int          STRIDE = 1,
   parameter int          PAD    = 1,
   parameter logic [31:0] SCALE  = 32'd16177215,
   parameter int          SHIFT  = 26,
   parameter logic [7:0]  IN_ZP  = 8'd0,
   parameter logic [7:0]  OUT_ZP = 8'd0,
   localparam int IN_AW = (IN_CH*IN_H*IN_W > 1) ? $clog2(IN_CH*IN_H*IN_W) : 1,
   localparam int W_AW  = (OUT_CH*IN_CH*K*K > 1) ? $clog2(OUT_CH*IN_CH*K*K) : 1,
   localparam int B_AW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic               in_we,
   input  logic [IN_AW-1:0]   in_addr,
   input  logic [7:0]         in_data,
   input  logic               w_we,
   input  logic [W_AW-1:0]    w_addr,
   input  logic [7:0]         w_data,
   input  logic               b_we,
   input  logic [B_AW-1:0]    b_addr,
   input  logic [31:0]        b_data,
`ifdef QCONV_PER_CHANNEL_SCALE_EN
   input  logic               s_we,
   input  logic [B_AW-1:0]    s_addr,
`endif
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int OUT_W = (IN_W + 2*PAD - K) / STRIDE + 1;
   localparam int OUT_H = (IN_H + 2*PAD - K) / STRIDE + 1;
   localparam int CW    = 16;

   // out_valid/out_ready: a result transfers on a rising edge where both are high;
   // out_data is held stable while out_valid=1 and out_ready=0.
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_REQ, S_OUT, S_FIN
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0] oc, oy, ox, ic, ky, kx;
   logic          ph;
   logic          tap_last, out_last, hs;

   logic [7:0]         in_mem [IN_CH*IN_H*IN_W];
   logic signed [7:0]  w_mem  [OUT_CH*IN_CH*K*K];
   logic signed [31:0] b_mem  [OUT_CH];

   logic [7:0]         in_q;
   logic signed [7:0]  w_q;
   logic signed [31:0] bias_q;
   logic [31:0]        scale_q;

   int                 iy, ix;
   logic               pad_tap;
   logic [IN_AW-1:0]   in_ra;
   logic [W_AW-1:0]    w_ra;

   logic               rd_v, pad_q, pr_v;
   logic signed [8:0]  act;
   logic signed [16:0] prod_nx, prod;
   logic signed [31:0] acc, sum;
   logic signed [63:0] sum_ext, scale_ext, mul_r, rnd, shd, val, zp64;
   logic [7:0]         req_val;

   assign tap_last = (ic == CW'(IN_CH-1)) && (ky == CW'(K-1)) && (kx == CW'(K-1));
   assign out_last = (oc == CW'(OUT_CH-1)) && (oy == CW'(OUT_H-1)) && (ox == CW'(OUT_W-1));
   assign hs       = (state == S_OUT) && out_ready;

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_LOAD;
         S_LOAD:  begin busy = 1'b1; state_nx = S_MAC; end
         S_MAC:   begin busy = 1'b1; if (tap_last) state_nx = S_DRAIN; end
         S_DRAIN: begin busy = 1'b1; if (ph) state_nx = S_REQ; end
         S_REQ:   begin busy = 1'b1; if (ph) state_nx = S_OUT; end
         S_OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = out_last ? S_FIN : S_LOAD;
         end
         S_FIN:   begin done = 1'b1; state_nx = S_IDLE; end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ph    <= 1'b0;
         oc <= '0; oy <= '0; ox <= '0;
         ic <= '0; ky <= '0; kx <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DRAIN || state == S_REQ) ph <= ~ph;
         if (state == S_MAC) begin
            if (kx == CW'(K-1)) begin
               kx <= '0;
               if (ky == CW'(K-1)) begin
                  ky <= '0;
                  ic <= (ic == CW'(IN_CH-1)) ? '0 : ic + CW'(1);
               end else begin
                  ky <= ky + CW'(1);
               end
            end else begin
               kx <= kx + CW'(1);
            end
         end
         if (hs) begin
            if (ox == CW'(OUT_W-1)) begin
               ox <= '0;
               if (oy == CW'(OUT_H-1)) begin
                  oy <= '0;
                  oc <= (oc == CW'(OUT_CH-1)) ? '0 : oc + CW'(1);
               end else begin
                  oy <= oy + CW'(1);
               end
            end else begin
               ox <= ox + CW'(1);
            end
         end
      end
   end

   // Padded taps read address 0; the registered pad flag zeroes their contribution.
   always_comb begin
      iy      = int'(oy) * STRIDE + int'(ky) - PAD;
      ix      = int'(ox) * STRIDE + int'(kx) - PAD;
      pad_tap = (iy < 0) || (iy >= IN_H) || (ix < 0) || (ix >= IN_W);
      in_ra   = pad_tap ? '0 : IN_AW'((int'(ic) * IN_H + iy) * IN_W + ix);
      w_ra    = W_AW'(((int'(oc) * IN_CH + int'(ic)) * K + int'(ky)) * K + int'(kx));
   end

   always_ff @(posedge clk) begin
      if (in_we && !busy) in_mem[in_addr] <= in_data;
      if (w_we && !busy)  w_mem[w_addr]   <= w_data;
      if (b_we && !busy)  b_mem[b_addr]   <= b_data;
      in_q <= in_mem[in_ra];
      w_q  <= w_mem[w_ra];
      if (state == S_LOAD) bias_q <= b_mem[oc[B_AW-1:0]];
   end

`ifdef QCONV_PER_CHANNEL_SCALE_EN
   logic [31:0] s_mem [OUT_CH];

   always_ff @(posedge clk) begin
      if (s_we && !busy) s_mem[s_addr] <= b_data;
      if (state == S_LOAD) scale_q <= s_mem[oc[B_AW-1:0]];
   end
`else
   assign scale_q = SCALE;
`endif

   always_comb begin
      act       = pad_q ? 9'sd0 : $signed({1'b0, in_q}) - $signed({1'b0, IN_ZP});
      prod_nx   = 17'(act) * 17'(w_q);
      sum       = acc + bias_q;
      sum_ext   = {{32{sum[31]}}, sum};
      scale_ext = {32'd0, scale_q};
      zp64      = {56'd0, OUT_ZP};
      rnd       = mul_r + (64'sd1 <<< (SHIFT - 1));
      shd       = rnd >>> SHIFT;
      val       = shd + zp64;
      // Clamping at the output zero point is the ReLU.
      if (val < zp64)         req_val = OUT_ZP;
      else if (val > 64'sd255) req_val = 8'd255;
      else                     req_val = val[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v     <= 1'b0;
         pad_q    <= 1'b0;
         pr_v     <= 1'b0;
         prod     <= '0;
         acc      <= '0;
         mul_r    <= '0;
         out_data <= '0;
      end else begin
         rd_v  <= (state == S_MAC);
         pad_q <= pad_tap;
         pr_v  <= rd_v;
         prod  <= prod_nx;
         if (state == S_LOAD)  acc <= '0;
         else if (pr_v)        acc <= acc + {{15{prod[16]}}, prod};
         if (state == S_REQ && !ph) mul_r    <= sum_ext * scale_ext;
         if (state == S_REQ && ph)  out_data <= req_val;
      end
   end

endmodule

// File: tb/tb_quant_conv_relu2d_stream.sv
// Self-checking bench for quant_conv_relu2d_stream: small strided/padded geometry, random data,
// expected outputs from a loop-level arithmetic model of the convolution.
module tb_quant_conv_relu2d_stream;
   localparam int          IN_CH = 2, OUT_CH = 3, K = 3, IN_W = 5, IN_H = 4, STRIDE = 2, PAD = 1;
   localparam logic [31:0] SCALE = 32'd200;
   localparam int          SHIFT = 12;
   localparam logic [7:0]  IN_ZP = 8'd10, OUT_ZP = 8'd4;
   localparam int OUT_W = (IN_W + 2*PAD - K) / STRIDE + 1;
   localparam int OUT_H = (IN_H + 2*PAD - K) / STRIDE + 1;
   localparam int N_OUT = OUT_CH * OUT_H * OUT_W;
   localparam int N_IN  = IN_CH * IN_H * IN_W;
   localparam int N_W   = OUT_CH * IN_CH * K * K;
   localparam int LAT   = IN_CH * K * K + 6;
   localparam int IN_AW = $clog2(N_IN), W_AW = $clog2(N_W), B_AW = $clog2(OUT_CH);

   logic clk, rst, start, busy, done;
   logic in_we, w_we, b_we, out_valid, out_ready;
   logic [IN_AW-1:0] in_addr;
   logic [W_AW-1:0]  w_addr;
   logic [B_AW-1:0]  b_addr;
   logic [7:0]  in_data, w_data, out_data;
   logic [31:0] b_data;
`ifdef QCONV_PER_CHANNEL_SCALE_EN
   logic s_we;
   logic [B_AW-1:0] s_addr;
`endif

   quant_conv_relu2d_stream #(
      .IN_CH(IN_CH), .OUT_CH(OUT_CH), .K(K), .IN_W(IN_W), .IN_H(IN_H), .STRIDE(STRIDE), .PAD(PAD),
      .SCALE(SCALE), .SHIFT(SHIFT), .IN_ZP(IN_ZP), .OUT_ZP(OUT_ZP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
`ifdef QCONV_PER_CHANNEL_SCALE_EN
      .s_we(s_we), .s_addr(s_addr),
`endif
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int pass_cnt = 0, total_cnt = 0;
   int in_m [N_IN];
   int w_m  [N_W];
   int b_m  [OUT_CH];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int hs_cyc[$];
   int done_cnt, stall_bad;
   bit timed_out;

   // reference model: direct convolution over the padded map, then requantize and clamp
   task automatic build_expected();
      exp_q.delete();
      for (int oc = 0; oc < OUT_CH; oc++)
         for (int oy = 0; oy < OUT_H; oy++)
            for (int ox = 0; ox < OUT_W; ox++) begin
               int acc, s, zin;
               longint m, r, v, zout;
               acc = 0; zin = int'(IN_ZP); zout = longint'(OUT_ZP);
               for (int c = 0; c < IN_CH; c++)
                  for (int ky = 0; ky < K; ky++)
                     for (int kx = 0; kx < K; kx++) begin
                        int y, x;
                        y = oy * STRIDE + ky - PAD;
                        x = ox * STRIDE + kx - PAD;
                        if (y >= 0 && y < IN_H && x >= 0 && x < IN_W)
                           acc += (in_m[(c * IN_H + y) * IN_W + x] - zin) * w_m[((oc * IN_CH + c) * K + ky) * K + kx];
                     end
               s = acc + b_m[oc];
               m = longint'(s) * longint'(SCALE);
               r = (m + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
               v = r + zout;
               if (v < zout) v = zout;
               if (v > 255)  v = 255;
               exp_q.push_back(8'(v));
            end
   endtask

   // driver tasks (entered and left at a falling edge)
   task automatic randomize_data();
      foreach (in_m[i]) in_m[i] = int'($urandom_range(40));
      foreach (w_m[i])  w_m[i]  = int'($urandom_range(16)) - 8;
      foreach (b_m[i])  b_m[i]  = int'($urandom_range(1000)) - 500;
   endtask

   task automatic load_bias();
      for (int i = 0; i < OUT_CH; i++) begin
         b_we = 1'b1; b_addr = B_AW'(i); b_data = b_m[i];
         @(negedge clk);
      end
      b_we = 1'b0;
`ifdef QCONV_PER_CHANNEL_SCALE_EN
      for (int i = 0; i < OUT_CH; i++) begin
         s_we = 1'b1; s_addr = B_AW'(i); b_data = SCALE;
         @(negedge clk);
      end
      s_we = 1'b0;
`endif
   endtask

   task automatic load_all();
      for (int i = 0; i < N_IN; i++) begin
         in_we = 1'b1; in_addr = IN_AW'(i); in_data = 8'(in_m[i]);
         @(negedge clk);
      end
      in_we = 1'b0;
      for (int i = 0; i < N_W; i++) begin
         w_we = 1'b1; w_addr = W_AW'(i); w_data = 8'(w_m[i]);
         @(negedge clk);
      end
      w_we = 1'b0;
      load_bias();
   endtask

   // Runs one job and records accepted outputs with the cycle of each handshake
   // (cycle 0 is the edge that samples start).
   task automatic run_job(input int ready_pct, input bit busy_writes, input bit wr_with_start);
      bit prev_stall, seen_done;
      logic [7:0] prev_data;
      int tail;
      got_q.delete(); hs_cyc.delete();
      done_cnt = 0; stall_bad = 0; timed_out = 1'b1;
      prev_stall = 1'b0; seen_done = 1'b0; prev_data = '0; tail = 0;
      start = 1'b1;
      if (wr_with_start) begin
         b_we = 1'b1; b_addr = B_AW'(OUT_CH - 1); b_data = b_m[OUT_CH - 1];
      end
      for (int c = 0; c < 5000; c++) begin
         if (c > 0) begin
            start = 1'b0; in_we = 1'b0; w_we = 1'b0; b_we = 1'b0;
         end
         if (busy_writes && c > 0 && !seen_done && busy && (c % 5 == 0)) begin
            start = 1'b1;
            in_we = 1'b1; in_addr = IN_AW'($urandom_range(N_IN - 1)); in_data = 8'($urandom);
            w_we  = 1'b1; w_addr  = W_AW'($urandom_range(N_W - 1));   w_data  = 8'($urandom);
            b_we  = 1'b1; b_addr  = B_AW'($urandom_range(OUT_CH - 1)); b_data = $urandom;
         end
         out_ready = ($urandom_range(99) < ready_pct);
         if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            hs_cyc.push_back(c);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (done) begin done_cnt++; seen_done = 1'b1; end
         if (seen_done) tail++;
         if (tail > 20) begin timed_out = 1'b0; break; end
         @(negedge clk);
      end
      start = 1'b0; in_we = 1'b0; w_we = 1'b0; b_we = 1'b0; out_ready = 1'b1;
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++; if (busy !== 1'b0)      $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0)      $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 8'd0)  $display("FAIL reset_data got=%0d exp=0", out_data); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_free_run();
      randomize_data();
      load_all();
      build_expected();
      run_job(100, 1'b0, 1'b0);
      total_cnt++; if (timed_out) $display("FAIL free_timeout got=no_done exp=done"); else pass_cnt++;
      total_cnt++; if (got_q.size() != N_OUT) $display("FAIL free_count got=%0d exp=%0d", got_q.size(), N_OUT); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL free_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++; if (done_cnt != 1) $display("FAIL free_done_pulses got=%0d exp=1", done_cnt); else pass_cnt++;
      if (hs_cyc.size() > 0) begin
         total_cnt++;
         if (hs_cyc[0] != LAT) $display("FAIL first_latency got=%0d exp=%0d", hs_cyc[0], LAT); else pass_cnt++;
      end
      for (int i = 1; i < hs_cyc.size(); i++) begin
         total_cnt++;
         if (hs_cyc[i] - hs_cyc[i-1] != LAT)
            $display("FAIL latency[%0d] got=%0d exp=%0d", i, hs_cyc[i] - hs_cyc[i-1], LAT);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      run_job(50, 1'b0, 1'b0);
      total_cnt++; if (timed_out) $display("FAIL bp_timeout got=no_done exp=done"); else pass_cnt++;
      total_cnt++; if (got_q.size() != N_OUT) $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), N_OUT); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++; if (stall_bad != 0) $display("FAIL bp_stable got=%0d_changes exp=0", stall_bad); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_clamp();
      b_m[0] = 32'h7fff_ffff;
      b_m[1] = -100000;
      b_m[2] = 100000;
      load_bias();
      build_expected();
      run_job(100, 1'b0, 1'b0);
      total_cnt++; if (got_q.size() != N_OUT) $display("FAIL clamp_count got=%0d exp=%0d", got_q.size(), N_OUT); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL clamp_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++;
      if (got_q.size() > OUT_H * OUT_W && got_q[OUT_H * OUT_W] !== OUT_ZP)
         $display("FAIL relu_floor got=%0d exp=%0d", got_q[OUT_H * OUT_W], OUT_ZP);
      else pass_cnt++;
   endtask

   task automatic test_write_with_start();
      randomize_data();
      load_all();
      b_m[OUT_CH - 1] = int'($urandom_range(4000)) - 2000;
      build_expected();
      run_job(100, 1'b0, 1'b1);
      total_cnt++; if (got_q.size() != N_OUT) $display("FAIL wrstart_count got=%0d exp=%0d", got_q.size(), N_OUT); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL wrstart_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
   endtask

   task automatic test_busy_ignore();
      run_job(100, 1'b1, 1'b0);
      total_cnt++; if (timed_out) $display("FAIL busy_timeout got=no_done exp=done"); else pass_cnt++;
      total_cnt++; if (got_q.size() != N_OUT) $display("FAIL busy_count got=%0d exp=%0d", got_q.size(), N_OUT); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL busy_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++; if (done_cnt != 1) $display("FAIL busy_done_pulses got=%0d exp=1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      total_cnt++; if (busy !== 1'b0)      $display("FAIL midrst_busy got=%b exp=0", busy); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (done !== 1'b0)      $display("FAIL midrst_done got=%b exp=0", done); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_job(100, 1'b0, 1'b0);
      total_cnt++; if (got_q.size() != N_OUT) $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), N_OUT); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL midrst_data[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      in_we = 1'b0; in_addr = '0; in_data = '0;
      w_we = 1'b0; w_addr = '0; w_data = '0;
      b_we = 1'b0; b_addr = '0; b_data = '0;
`ifdef QCONV_PER_CHANNEL_SCALE_EN
      s_we = 1'b0; s_addr = '0;
`endif
      @(negedge clk);
      test_reset();
      test_free_run();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_clamp();
      test_write_with_start();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/quant_conv_relu2d_stream.md
Name: quant_conv_relu2d_stream

Overview:
- Parametrised successor to the fixed-geometry quantized Conv+ReLU engine.
- Adds configurable stride and on-the-fly zero padding, so the input buffer holds only the unpadded feature map.
- Adds an input zero point and a valid/ready output stream with backpressure.
- Sits between the layer loader (input, weight and bias write ports) and the next layer's input buffer. One multiply-accumulate per cycle.

Parameters:
- IN_CH, 1, input channels
- OUT_CH, 32, output channels
- K, 3, square kernel size
- IN_W, 28, unpadded input width
- IN_H, 28, unpadded input height
- STRIDE, 1, convolution stride (≥1)
- PAD, 1, zero-pad border width (0..K-1)
- SCALE, 32'd16177215, unsigned requant multiplier, Q(SHIFT)
- SHIFT, 26, right shift applied after the SCALE multiply
- IN_ZP, 8'd0, input activation zero point
- OUT_ZP, 8'd0, output zero point; also the ReLU floor

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- start  in  1  single-cycle start pulse, sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last output is accepted
- in_we  in  1  input buffer write enable
- in_addr  in  clog2(IN_CH*IN_H*IN_W)  input address, ordered [ic][y][x]
- in_data  in  8  uint8 activation
- w_we  in  1  weight buffer write enable
- w_addr  in  clog2(OUT_CH*IN_CH*K*K)  weight address, ordered [oc][ic][ky][kx]
- w_data  in  8  int8 weight
- b_we  in  1  bias buffer write enable
- b_addr  in  clog2(OUT_CH)  bias address
- b_data  in  32  int32 bias
- out_data  out  8  uint8 requantized result
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accept

Behaviour:
- Reset: asynchronous, active high. Memories are not cleared.
  - Outputs reset to busy=0, done=0, out_valid=0, out_data=0.
  - Internal state: FSM→IDLE, all counters 0.
  - Reset asserted mid-operation aborts the run; buffer contents are kept.
- Output geometry: OUT_W=(IN_W+2*PAD-K)/STRIDE+1; OUT_H likewise. Integer division.
- Output order: oc outermost, then oy, then ox. Reduction order inside each output: ic, ky, kx.
- Writes:
  - Accepted only while busy=0; ignored while busy=1.
  - start is ignored while busy=1.
  - A write and start in the same IDLE cycle: the write takes effect, then the run begins.
- FSM states: IDLE → LOAD → MAC → DRAIN → REQ → OUT → (LOAD | FIN) → IDLE.
  - IDLE: wait for start.
  - LOAD (1 cycle): clear the accumulator; issue the bias read for the current oc.
  - MAC (IN_CH*K*K cycles): issue one tap per cycle. Tap coordinates are iy=oy*STRIDE+ky-PAD and ix=ox*STRIDE+kx-PAD. If the tap falls outside 0..IN_H-1 or 0..IN_W-1, the activation is IN_ZP, so its contribution is zero. Memories are synchronous-read with 1-cycle latency.
  - DRAIN (2 cycles): flush the read and multiply pipeline.
  - REQ (2 cycles), arithmetic:
    - Each tap product is (in-IN_ZP), signed 9-bit, times w, int8, accumulated in a 32-bit signed accumulator.
    - acc+bias is computed with 32-bit wraparound.
    - Multiply by SCALE to a 64-bit signed result; add 2^(SHIFT-1) and arithmetic-shift right by SHIFT (round half up); add OUT_ZP.
    - Clamp to [OUT_ZP,255]; this clamp is the ReLU.
  - OUT: out_valid=1 and out_data is held stable until out_ready=1. out_valid falls on the cycle after the handshake. Then go to LOAD for the next output, or FIN after the last one.
  - FIN: done=1 for one cycle; busy falls in the same cycle; next state IDLE.
- Latency per output with out_ready held high: IN_CH*K*K+6 cycles from LOAD to the handshake.
- Backpressure: while out_ready=0 the engine stalls in OUT. No data is dropped and no counter advances.

Optional Feature:
- Macro: QCONV_PER_CHANNEL_SCALE_EN.
- Defined: adds a 32-bit per-channel scale buffer with ports s_we (in, 1) and s_addr (in, clog2(OUT_CH)). The scale shares b_data as its write data. The buffer is read in LOAD alongside the bias, and REQ uses the per-channel value instead of SCALE.
- Undefined: the ports are absent and the SCALE parameter is used for every channel.

Test Plan:
- Defaults: IN_CH=1, OUT_CH=32, K=3, 28x28, STRIDE=1, PAD=1; load golden vector files; out_ready=1 → exactly 32*28*28 outputs in [oc][oy][ox] order, all matching expected, then a single done pulse.
- IN_W=IN_H=5, PAD=0, STRIDE=2, OUT_CH=1, all inputs 1, all weights 1, bias 0, SCALE=2^26, SHIFT=26 → 4 outputs, each 9; per-output latency 15 cycles.
- Same 5x5 as above but PAD=1, STRIDE=1, IN_ZP=1, inputs=1 → every output equals 0 (zero-point padding); negative bias -100 with OUT_ZP=3 → output clamped to 3.
- out_ready toggled by a random 50% pattern → out_data stable while out_valid=1 and out_ready=0; output count and values identical to the free-flowing run.
- Assert rst for 1 cycle mid-MAC → busy, out_valid and done all 0 immediately; restart without reloading buffers → full correct output.
- start pulsed and writes issued while busy → ignored; result unchanged, exactly one done pulse.
